// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet receive path: arbiter state encoding,
// default frame-counter width and the AXI-Stream tuser layout used between
// the RX arbiter and eth_parser.
// ---------------------------------------------------------------------------
package eth_pkg;

  // Arbiter state: waiting for a request, or locked onto one port's frame.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_t;

  // Default width of each per-port completed-frame counter.
  localparam int unsigned CNT_WIDTH_DEF = 16;

  // tuser layout shared with eth_parser: MAC-match flags then EtherType.
  localparam int unsigned TUSER_MAC_LSB   = 0;
  localparam int unsigned TUSER_MAC_W     = 2;
  localparam int unsigned TUSER_ETYPE_LSB = 2;
  localparam int unsigned TUSER_ETYPE_W   = 16;
  localparam int unsigned TUSER_WIDTH     = TUSER_ETYPE_LSB + TUSER_ETYPE_W;

endpackage : eth_pkg

// File: rtl/rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin priority scan: returns the first asserted
// request found scanning upward from ptr, wrapping modulo NUM_PORTS.
//
// Ports:
//   req     in  NUM_PORTS  request vector
//   ptr     in  ID_WIDTH   index that has highest priority this cycle
//   gnt_idx out ID_WIDTH   index of the selected request (0 when none)
//   any     out 1          at least one request is asserted
// ---------------------------------------------------------------------------
module rr_select #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ID_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  ptr,
  output logic [ID_WIDTH-1:0]  gnt_idx,
  output logic                 any
);

  // Walk the offsets from ptr; the first hit wins and later hits are ignored.
  always_comb begin
    int unsigned        idx;
    logic [ID_WIDTH-1:0] cand;
    idx     = 0;
    cand    = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      idx  = (32'(ptr) + off) % NUM_PORTS;
      cand = ID_WIDTH'(idx);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule : rr_select

// File: rtl/eth_rx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_rx_arbiter
// Packet-level round-robin arbiter sharing one AXI-Stream consumer between
// NUM_PORTS MAC receive streams. A grant is held from a frame's first beat
// until its tlast handshake so frames never interleave; the source index is
// forwarded on m_axis_tid and completed frames are counted per port.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   s_axis_*         NUM_PORTS upstream streams (data packed port-major)
//   m_axis_*         single downstream stream, tid = granted port
//   busy             a grant is currently held
//   stat_frame_cnt   NUM_PORTS counters of CNT_WIDTH, wrap without saturation
// ---------------------------------------------------------------------------
module eth_rx_arbiter
  import eth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_PORTS),
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  input  logic                            m_axis_tready,
  output logic                            busy,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  stat_frame_cnt
);

  arb_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];

  logic [ID_WIDTH-1:0]   sel_idx;
  logic                  sel_any;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  eof_hs;

  // Next grant candidate, scanning from the round-robin pointer.
  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_rr_select (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr_q),
    .gnt_idx (sel_idx),
    .any     (sel_any)
  );

  // View of the currently granted upstream port.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        g_valid = s_axis_tvalid[i];
        g_last  = s_axis_tlast[i];
        g_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Final beat of the granted frame is accepted this cycle.
  assign eof_hs = (state_q == S_GRANT) && g_valid && m_axis_tready && g_last;

  // Next-state, grant, pointer and counter update.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (sel_any) begin
          grant_d = sel_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Grant is held until tlast is accepted; a stalled source holds it.
        if (eof_hs) begin
          state_d  = S_IDLE;
          rr_ptr_d = (grant_q == ID_WIDTH'(NUM_PORTS - 1)) ? '0
                                                           : grant_q + ID_WIDTH'(1);
          for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
              cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, grant, pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output mux: pass-through of the granted port; everything quiet in idle.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    m_axis_tdata  = g_data;
    busy          = (state_q == S_GRANT);
    if (state_q == S_GRANT) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        s_axis_tready[i] = (grant_q == ID_WIDTH'(i)) && m_axis_tready;
      end
      m_axis_tvalid = g_valid;
      m_axis_tlast  = g_last;
      m_axis_tid    = grant_q;
    end
  end

  // Flatten counters onto the status bus, port i at [i*CNT_WIDTH +: CNT_WIDTH].
  always_comb begin
    stat_frame_cnt = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      stat_frame_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

endmodule : eth_rx_arbiter

// File: tb/tb_eth_rx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_arbiter
// Self-checking bench for eth_rx_arbiter (4 ports, 8-bit data, 8-bit counters
// so counter wrap is reachable quickly). Directed table, hand sequences for
// reset, fairness, backpressure and wrap, then random traffic against a
// frame-level reference model.
// ---------------------------------------------------------------------------
module tb_eth_rx_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned CV = NP * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0] s_tvalid;
  logic [NP-1:0] s_tlast;
  logic [NP-1:0] s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [IW-1:0] m_tid;
  logic          m_tready;
  logic          busy;
  logic [CV-1:0] stat;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: is a frame in progress, which port owns it, who is next.
  bit md_busy;
  int md_g;
  int md_ptr;
  int md_cnt[NP];

  always #5 clk = ~clk;

  eth_rx_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_PORTS  (NP),
    .ID_WIDTH   (IW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tid     (m_tid),
    .m_axis_tready  (m_tready),
    .busy           (busy),
    .stat_frame_cnt (stat)
  );

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic        e_last;
    logic [1:0]  e_tid;
    logic        e_busy;
    logic [7:0]  e_data;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pbyte(input logic [31:0] d, input int p);
    return 8'(d >> (8 * p));
  endfunction

  task automatic model_reset();
    md_busy = 1'b0;
    md_g    = 0;
    md_ptr  = 0;
    for (int i = 0; i < NP; i++) md_cnt[i] = 0;
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic mr);
    rst      = r;
    s_tvalid = v;
    s_tlast  = l;
    s_tdata  = d;
    m_tready = mr;
  endtask

  // Clock edge, then apply the frame-level rules to the inputs just seen.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (md_busy) begin
      if (1'(s_tvalid >> md_g) && m_tready && 1'(s_tlast >> md_g)) begin
        md_cnt[md_g] = (md_cnt[md_g] + 1) % (1 << CW);
        md_ptr       = (md_g + 1) % NP;
        md_busy      = 1'b0;
      end
    end else if (s_tvalid != '0) begin
      for (int k = 0; k < NP; k++) begin
        if (1'(s_tvalid >> ((md_ptr + k) % NP))) begin
          md_g = (md_ptr + k) % NP;
          break;
        end
      end
      md_busy = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic check_model();
    logic [NP-1:0] e_rdy;
    logic          e_val;
    logic          e_last;
    logic [IW-1:0] e_tid;
    logic [CV-1:0] e_cnt;
    e_rdy  = '0;
    e_val  = 1'b0;
    e_last = 1'b0;
    e_tid  = '0;
    e_cnt  = '0;
    if (md_busy) begin
      e_rdy  = NP'(m_tready) << md_g;
      e_val  = 1'(s_tvalid >> md_g);
      e_last = 1'(s_tlast >> md_g);
      e_tid  = IW'(md_g);
    end
    for (int i = 0; i < NP; i++) e_cnt = e_cnt | (CV'(md_cnt[i]) << (i * CW));
    cmp("tready", 64'(s_tready), 64'(e_rdy));
    cmp("m_tvalid", 64'(m_tvalid), 64'(e_val));
    cmp("m_tlast", 64'(m_tlast), 64'(e_last));
    cmp("m_tid", 64'(m_tid), 64'(e_tid));
    cmp("busy", 64'(busy), 64'(md_busy));
    cmp("frame_cnt", 64'(stat), 64'(e_cnt));
    if (e_val) cmp("m_tdata", 64'(m_tdata), 64'(pbyte(s_tdata, md_g)));
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic mr);
    drive(r, v, l, d, mr);
    #1;
    check_model();
    advance();
  endtask

  initial begin
    int          b[NP];
    int          tids[$];
    logic [7:0]  dut_acc[$];
    logic [3:0]  l;
    logic [31:0] d;
    int          k;
    bit          done;
    bit          was;

    drive(1'b1, '0, '0, '0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Contention (ports 1,3 from ptr 0) then single-port 3-beat frame on port 0.
    //          v        l        d              rdy     val   last  tid   busy  data   cnt
    tbl[0]  = '{4'b1010, 4'b0000, 32'h31001100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h00000000};
    tbl[1]  = '{4'b1010, 4'b0000, 32'h31001100, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b1, 8'h11, 32'h00000000};
    tbl[2]  = '{4'b1010, 4'b0010, 32'h31001200, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 8'h12, 32'h00000000};
    tbl[3]  = '{4'b1000, 4'b0000, 32'h31000000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h00000100};
    tbl[4]  = '{4'b1000, 4'b0000, 32'h31000000, 4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 8'h31, 32'h00000100};
    tbl[5]  = '{4'b1000, 4'b1000, 32'h32000000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 8'h32, 32'h00000100};
    tbl[6]  = '{4'b0001, 4'b0000, 32'h000000A1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h01000100};
    tbl[7]  = '{4'b0001, 4'b0000, 32'h000000A1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 8'hA1, 32'h01000100};
    tbl[8]  = '{4'b0001, 4'b0000, 32'h000000A2, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 8'hA2, 32'h01000100};
    tbl[9]  = '{4'b0001, 4'b0001, 32'h000000A3, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 8'hA3, 32'h01000100};
    tbl[10] = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h01000101};

    for (int i = 0; i < 11; i++) begin
      drive(1'b0, tbl[i].v, tbl[i].l, tbl[i].d, 1'b1);
      #1;
      cmp($sformatf("tbl%0d_tready", i), 64'(s_tready), 64'(tbl[i].e_rdy));
      cmp($sformatf("tbl%0d_tvalid", i), 64'(m_tvalid), 64'(tbl[i].e_val));
      cmp($sformatf("tbl%0d_tlast", i), 64'(m_tlast), 64'(tbl[i].e_last));
      cmp($sformatf("tbl%0d_tid", i), 64'(m_tid), 64'(tbl[i].e_tid));
      cmp($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      cmp($sformatf("tbl%0d_cnt", i), 64'(stat), 64'(tbl[i].e_cnt));
      if (tbl[i].e_val) cmp($sformatf("tbl%0d_tdata", i), 64'(m_tdata), 64'(tbl[i].e_data));
      advance();
    end

    // Reset on beat 2 of a port 1 frame, then a normal port 2 frame.
    step(1'b0, 4'b0010, 4'b0000, 32'h00005100, 1'b1);
    step(1'b0, 4'b0010, 4'b0000, 32'h00005100, 1'b1);
    step(1'b1, 4'b0010, 4'b0000, 32'h00005200, 1'b1);
    drive(1'b0, 4'b0100, 4'b0000, 32'h00610000, 1'b1);
    #1;
    cmp("rst_tready", 64'(s_tready), 64'(0));
    cmp("rst_tvalid", 64'(m_tvalid), 64'(0));
    cmp("rst_busy", 64'(busy), 64'(0));
    cmp("rst_cnt", 64'(stat), 64'(0));
    advance();
    step(1'b0, 4'b0100, 4'b0000, 32'h00610000, 1'b1);
    step(1'b0, 4'b0100, 4'b0100, 32'h00620000, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1);

    // Fairness: every port always valid with 2-beat frames.
    step(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);
    for (int p = 0; p < NP; p++) b[p] = 0;
    for (int c = 0; c < 27; c++) begin
      l = '0;
      d = '0;
      for (int p = 0; p < NP; p++) begin
        if (b[p] == 1) l = l | (4'd1 << p);
        d = d | (32'(8'(16 * p + b[p])) << (8 * p));
      end
      drive(1'b0, 4'b1111, l, d, 1'b1);
      #1;
      check_model();
      if (m_tvalid && b[md_g] == 0) tids.push_back(int'(m_tid));
      if (md_busy) b[md_g] = (b[md_g] + 1) % 2;
      if (c == 24) cmp("fair_cnt", 64'(stat), 64'(32'h02020202));
      advance();
    end
    cmp("fair_nframes", 64'(tids.size()), 64'(9));
    for (int i = 0; i < tids.size() && i < 9; i++)
      cmp($sformatf("fair_tid%0d", i), 64'(tids[i]), 64'(i % NP));
    step(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);

    // Backpressure: port 2 sends 5 beats while m_tready toggles; 0 and 3 wait.
    k    = 0;
    done = 1'b0;
    for (int c = 0; c < 24 && !done; c++) begin
      d = {8'h3F, 8'(8'hA0 + k), 8'h00, 8'h0F};
      l = (k == 4) ? 4'b0100 : 4'b0000;
      drive(1'b0, 4'b1101, l, d, 1'(c % 2));
      #1;
      check_model();
      if (m_tvalid && m_tready) dut_acc.push_back(m_tdata);
      was = md_busy;
      if (md_busy && m_tready) k++;
      advance();
      if (was && !md_busy) done = 1'b1;
    end
    cmp("bp_done", 64'(done), 64'(1));
    cmp("bp_nbeats", 64'(dut_acc.size()), 64'(5));
    for (int i = 0; i < dut_acc.size() && i < 5; i++)
      cmp($sformatf("bp_beat%0d", i), 64'(dut_acc[i]), 64'(8'hA0 + i));
    step(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);

    // Counter wrap: 256 single-beat frames on port 0.
    step(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);
    for (int f = 0; f < 256; f++) begin
      step(1'b0, 4'b0001, 4'b0001, 32'(f), 1'b1);
      step(1'b0, 4'b0001, 4'b0001, 32'(f), 1'b1);
      if (f == 254) cmp("wrap_full", 64'(stat[7:0]), 64'(8'hFF));
    end
    cmp("wrap_zero", 64'(stat[7:0]), 64'(0));
    step(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step(1'(($urandom % 300) == 0), 4'($urandom), 4'($urandom) & 4'($urandom),
           $urandom, 1'(($urandom % 4) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_eth_rx_arbiter
